// File: rtl/egress_pkg.sv
// Shared types and constants for the egress drain stage.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package egress_pkg;

    localparam int   BW_DEFAULT = 6;
    localparam logic SRC_D0     = 1'b0;
    localparam logic SRC_D1     = 1'b1;

    // One buffered egress word: the source tag sits above the payload.
    typedef struct packed {
        logic                  src;
        logic [BW_DEFAULT-1:0] data;
    } egress_word_t;

    localparam int WORD_W = $bits(egress_word_t);

endpackage

// File: rtl/egress_out_buf.sv
// Two-entry register FIFO of tagged egress words, with push, pop and occupancy count.
// Latency: a pushed word is visible at the head the cycle after the push (when the FIFO was empty).
// Backpressure: the caller never pushes into a full FIFO unless it pops in the same cycle.
module egress_out_buf
    import egress_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [WORD_W-1:0] push_word,
    input  logic              pop,
    output logic [WORD_W-1:0] head,
    output logic [1:0]        count
);

    logic [WORD_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;

    // Storage, pointers and occupancy. On a full push+pop the write lands in the slot
    // being vacated by the head, so ordering is preserved.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head = mem[rd_ptr];

    // Overflow and underflow are design errors upstream.
    a_no_overflow:  assert property (@(posedge clk) disable iff (reset) !(push && !pop && count == 2'd2));
    a_no_underflow: assert property (@(posedge clk) disable iff (reset) !(pop && count == 2'd0));

endmodule

// File: rtl/egress_rr_drain.sv
// Round-robin drain of the D0/D1 destination FIFOs onto one source-tagged valid/ready egress stream.
// Latency: Di_rd in cycle N gives eg_valid in N+1 (in-flight word bypasses an empty buffer); 1 word/cycle.
// Backpressure: pops are issued only against free buffer credit; with eg_ready low the head is held.
// Build option EGRESS_COUNT_EN: adds 16-bit per-source accepted-word counters cnt_d0 / cnt_d1.
module egress_rr_drain
    import egress_pkg::*;
#(
    parameter int BW     = BW_DEFAULT,  // egress_word_t is sized by BW_DEFAULT; keep them equal
    parameter int OBUF_D = 2            // output buffer depth; only 2 is supported
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          D0_empty,
    input  logic          D0_error_output,
    input  logic [BW-1:0] D0_data_out,
    output logic          D0_rd,
    input  logic          D1_empty,
    input  logic          D1_error_output,
    input  logic [BW-1:0] D1_data_out,
    output logic          D1_rd,
    input  logic          eg_ready,
    output logic          eg_valid,
    output logic [BW-1:0] eg_data,
    output logic          eg_src,
`ifdef EGRESS_COUNT_EN
    output logic [15:0]   cnt_d0,
    output logic [15:0]   cnt_d1,
`endif
    output logic [1:0]    err_sticky
);

    localparam logic [1:0] CREDIT_LIMIT = 2'(OBUF_D);

    logic         d0_elig;
    logic         d1_elig;
    logic         inflight_q;
    logic         inflight_src_q;
    logic         last_src_q;
    logic [1:0]   buf_count;
    logic [1:0]   committed;
    logic         accept;
    logic         bypass;
    logic         credit_ok;
    logic         buf_push;
    logic         buf_pop;
    egress_word_t inflight_word;
    egress_word_t head_word;

    assign d0_elig = ~D0_empty & ~D0_error_output;
    assign d1_elig = ~D1_empty & ~D1_error_output;
    assign accept  = eg_valid & eg_ready;

    // Words already owned by this stage (buffered + in flight), less the one leaving this cycle.
    assign committed = buf_count + {1'b0, inflight_q} - {1'b0, accept};
    assign credit_ok = ~reset & (committed < CREDIT_LIMIT);

    assign inflight_word.src  = inflight_src_q;
    assign inflight_word.data = inflight_src_q ? D1_data_out : D0_data_out;

    // The in-flight word is presented directly when the buffer is empty; otherwise it queues behind.
    assign bypass   = (buf_count == 2'd0) & inflight_q;
    assign eg_valid = (buf_count != 2'd0) | inflight_q;
    assign eg_data  = bypass ? inflight_word.data : head_word.data;
    assign eg_src   = bypass ? inflight_word.src  : head_word.src;
    assign buf_push = inflight_q & ~(bypass & eg_ready);
    assign buf_pop  = (buf_count != 2'd0) & eg_ready;

    // Round-robin grant: alternate when both are eligible, otherwise serve whichever is.
    always_comb begin
        D0_rd = 1'b0;
        D1_rd = 1'b0;
        if (credit_ok) begin
            if (d0_elig && d1_elig) begin
                if (last_src_q == SRC_D0) begin
                    D1_rd = 1'b1;
                end else begin
                    D0_rd = 1'b1;
                end
            end else if (d0_elig) begin
                D0_rd = 1'b1;
            end else if (d1_elig) begin
                D1_rd = 1'b1;
            end
        end
    end

    // In-flight tracking, RR pointer (reset so D0 wins first) and sticky error capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q     <= 1'b0;
            inflight_src_q <= SRC_D0;
            last_src_q     <= SRC_D1;
            err_sticky     <= 2'b00;
        end else begin
            inflight_q     <= D0_rd | D1_rd;
            inflight_src_q <= D1_rd ? SRC_D1 : SRC_D0;
            if (D0_rd || D1_rd) begin
                last_src_q <= D1_rd ? SRC_D1 : SRC_D0;
            end
            err_sticky <= err_sticky | {D1_error_output, D0_error_output};
        end
    end

`ifdef EGRESS_COUNT_EN
    // Per-source count of words accepted by the sink; free-running wrap at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_d0 <= 16'd0;
            cnt_d1 <= 16'd0;
        end else if (accept) begin
            if (eg_src == SRC_D1) begin
                cnt_d1 <= cnt_d1 + 16'd1;
            end else begin
                cnt_d0 <= cnt_d0 + 16'd1;
            end
        end
    end
`endif

    egress_out_buf u_out_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (buf_push),
        .push_word (inflight_word),
        .pop       (buf_pop),
        .head      (head_word),
        .count     (buf_count)
    );

    a_occ_max: assert property (@(posedge clk) disable iff (reset) buf_count <= 2'd2);
    a_one_rd:  assert property (@(posedge clk) disable iff (reset) !(D0_rd && D1_rd));

endmodule
